test002_methods: RTL and testbench

- Hardware-compiled method object: one 32-bit array `a`, two 32-bit fields `x` and `y`, and nine callable methods.
- Each method has its own req/busy handshake, and only one method executes at a time.
- The top-level method `test` runs a fixed internal self-check sequence and returns a pass flag.
- The block is a leaf used as a self-checking unit in system regression.

---
 rtl/test002_pkg.sv | 42 ++++
 rtl/test002_dpram.sv | 43 ++++
 rtl/test002_methods.sv | 226 ++++++++++++++++++++++
 tb/tb_test002_methods.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/test002_pkg.sv
// test002_pkg: shared types and constants for the test002_methods method object.
// Contents:
//   WORD_W       - data word width
//   SW_*         - switch_test result constants
//   method_e     - method IDs, in arbitration priority order (init highest)
//   state_e      - FSM states of the method sequencer
//   switch_val   - switch_test mapping
//   start_state  - first FSM state of each method
package test002_pkg;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] SW_0   = 32'd10;
    localparam logic [WORD_W-1:0] SW_1   = 32'd20;
    localparam logic [WORD_W-1:0] SW_2   = 32'd30;
    localparam logic [WORD_W-1:0] SW_DEF = 32'hFFFF_FFFF;

    typedef enum logic [3:0] {
        M_INIT, M_DEC, M_INC, M_COPY, M_SET, M_GET, M_SWITCH, M_SUM, M_TEST
    } method_e;

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_DEC, S_INC, S_COPY_RD, S_COPY_WR, S_SET,
        S_GET_RD, S_GET_WAIT, S_SWITCH, S_SUM, S_TEST
    } state_e;

    function automatic logic [WORD_W-1:0] switch_val(input logic [WORD_W-1:0] x);
        return x == 0 ? SW_0 : x == 1 ? SW_1 : x == 2 ? SW_2 : SW_DEF;
    endfunction

    function automatic state_e start_state(input method_e m);
        case (m)
            M_INIT:   return S_INIT;
            M_DEC:    return S_DEC;
            M_INC:    return S_INC;
            M_COPY:   return S_COPY_RD;
            M_SET:    return S_SET;
            M_GET:    return S_GET_RD;
            M_SWITCH: return S_SWITCH;
            M_SUM:    return S_SUM;
            default:  return S_TEST;
        endcase
    endfunction
endpackage

// File: rtl/test002_dpram.sv
// test002_dpram: dual-port synchronous RAM of ARRAY_LEN 32-bit words.
// Ports:
//   i_clk, i_rst_n            - clock, async active-low reset (port B read register only)
//   i_a_we/i_a_addr/i_a_din   - internal port write; o_a_dout reads i_a_addr every cycle (1-cycle latency)
//   i_b_we/i_b_addr/i_b_din   - external port write
//   i_b_oe/o_b_dout           - external port read enable / data (1-cycle latency, holds otherwise)
// Same-address writes on both ports in one cycle: port A (internal) wins.
module test002_dpram
    import test002_pkg::*;
#(
    parameter int ARRAY_LEN = 128,
    localparam int AW = $clog2(ARRAY_LEN)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_a_we,
    input  logic [AW-1:0]     i_a_addr,
    input  logic [WORD_W-1:0] i_a_din,
    output logic [WORD_W-1:0] o_a_dout,
    input  logic              i_b_we,
    input  logic              i_b_oe,
    input  logic [AW-1:0]     i_b_addr,
    input  logic [WORD_W-1:0] i_b_din,
    output logic [WORD_W-1:0] o_b_dout
);
    logic [WORD_W-1:0] r_mem [ARRAY_LEN];
    logic [WORD_W-1:0] r_a_dout;
    logic [WORD_W-1:0] r_b_dout;

    // Port A is written last so it overrides port B on an address clash.
    always_ff @(posedge i_clk) begin
        if (i_b_we) r_mem[i_b_addr] <= i_b_din;
        if (i_a_we) r_mem[i_a_addr] <= i_a_din;
        r_a_dout <= r_mem[i_a_addr];
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_b_dout <= '0;
        else if (i_b_oe) r_b_dout <= r_mem[i_b_addr];

    assign o_a_dout = r_a_dout;
    assign o_b_dout = r_b_dout;
endmodule

// File: rtl/test002_methods.sv
// test002_methods: hardware method object (array a, fields x/y, nine methods, one at a time).
// Ports:
//   clk, reset                 - clock, async active-low reset
//   a_address/a_we/a_oe/a_din/a_dout/a_length - external array port, a_length = ARRAY_LEN
//   x_in/x_we/x_out, y_in/y_we/y_out          - external field write / readback
//   dec_i inc_i get_i switch_test_x copy_i copy_j set_i set_v - method arguments
//   <m>_req/<m>_busy/<m>_return               - per-method call handshake and result
// Build option: ARRAY_EXT_PORT_EN enables the external array port; otherwise a_we/a_oe are
// ignored and a_dout reads 0.
module test002_methods
    import test002_pkg::*;
#(
    parameter int ARRAY_LEN = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a_address,
    input  logic        a_we,
    input  logic        a_oe,
    input  logic [31:0] a_din,
    output logic [31:0] a_dout,
    output logic [31:0] a_length,
    input  logic [31:0] x_in,
    input  logic        x_we,
    output logic [31:0] x_out,
    input  logic [31:0] y_in,
    input  logic        y_we,
    output logic [31:0] y_out,
    input  logic [31:0] dec_i,
    input  logic [31:0] inc_i,
    input  logic [31:0] get_i,
    input  logic [31:0] switch_test_x,
    input  logic [31:0] copy_i,
    input  logic [31:0] copy_j,
    input  logic [31:0] set_i,
    input  logic [31:0] set_v,
    input  logic        init_req,
    input  logic        dec_req,
    input  logic        inc_req,
    input  logic        copy_req,
    input  logic        set_req,
    input  logic        get_req,
    input  logic        switch_test_req,
    input  logic        sum_x_y_req,
    input  logic        test_req,
    output logic        init_busy,
    output logic        dec_busy,
    output logic        inc_busy,
    output logic        copy_busy,
    output logic        set_busy,
    output logic        get_busy,
    output logic        switch_test_busy,
    output logic        sum_x_y_busy,
    output logic        test_busy,
    output logic [31:0] dec_return,
    output logic [31:0] inc_return,
    output logic [31:0] get_return,
    output logic [31:0] switch_test_return,
    output logic [31:0] sum_x_y_return,
    output logic        test_return
);
    localparam int AW = $clog2(ARRAY_LEN);

    state_e            r_state;
    logic [8:0]        r_busy;
    logic              r_in_test, r_pass, r_chk, r_test_ret;
    logic [3:0]        r_step;
    logic [AW-1:0]     r_cnt, r_ia, r_ib;
    logic [WORD_W-1:0] r_arg, r_res, r_exp, r_x, r_y;
    logic [WORD_W-1:0] r_dec_ret, r_inc_ret, r_get_ret, r_sw_ret, r_sum_ret;
    logic [8:0]        w_req;
    method_e           w_sel;
    logic              w_done, w_pass, w_we, w_b_we, w_b_oe, w_unused;
    logic [AW-1:0]     w_addr, w_b_addr;
    logic [WORD_W-1:0] w_din, w_res, w_ram_q, w_b_din, w_b_q;

    assign w_req = {test_req, sum_x_y_req, switch_test_req, get_req, set_req,
                    copy_req, inc_req, dec_req, init_req};

    // Lowest index wins, matching method_e priority.
    always_comb begin
        w_sel = M_TEST;
        for (int k = 8; k >= 0; k--) if (w_req[k]) w_sel = method_e'(k[3:0]);
    end

    always_comb begin
        w_done = r_state == S_INIT ? r_cnt == AW'(ARRAY_LEN - 1)
               : r_state inside {S_DEC, S_INC, S_COPY_WR, S_SET, S_GET_WAIT, S_SWITCH, S_SUM};
        w_res  = r_state == S_DEC      ? r_arg - 1
               : r_state == S_INC      ? r_arg + 1
               : r_state == S_GET_WAIT ? w_ram_q
               : r_state == S_SWITCH   ? switch_val(r_arg)
               : r_state == S_SUM      ? r_x + r_y : '0;
        // Running test verdict including the result that just came back.
        w_pass = r_pass & (!r_chk | (r_res == r_exp));
        w_we   = r_state inside {S_INIT, S_SET, S_COPY_WR};
        w_addr = r_state == S_INIT ? r_cnt : r_state == S_COPY_WR ? r_ib : r_ia;
        w_din  = r_state == S_INIT ? WORD_W'(r_cnt) : r_state == S_COPY_WR ? w_ram_q : r_arg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_busy <= '0;
            r_in_test <= 1'b0;
            r_pass <= 1'b0;
            r_chk <= 1'b0;
            r_step <= '0;
            r_cnt <= '0;
            r_ia <= '0;
            r_ib <= '0;
            r_arg <= '0;
            r_res <= '0;
            r_exp <= '0;
            r_x <= '0;
            r_y <= '0;
            r_dec_ret <= '0;
            r_inc_ret <= '0;
            r_get_ret <= '0;
            r_sw_ret <= '0;
            r_sum_ret <= '0;
            r_test_ret <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (|w_req) begin
                    r_state <= start_state(w_sel);
                    r_busy <= 9'b1 << w_sel;
                    r_in_test <= w_sel == M_TEST;
                    r_pass <= 1'b1;
                    r_chk <= 1'b0;
                    r_step <= '0;
                    r_cnt <= '0;
                    r_arg <= w_sel == M_DEC ? dec_i : w_sel == M_INC ? inc_i
                           : w_sel == M_SWITCH ? switch_test_x : set_v;
                    r_ia <= w_sel == M_COPY ? copy_i[AW-1:0] : w_sel == M_SET ? set_i[AW-1:0]
                          : get_i[AW-1:0];
                    r_ib <= copy_j[AW-1:0];
                end
                // Test sequencer: score the previous call, then issue the next one.
                S_TEST: begin
                    r_pass <= w_pass;
                    r_step <= r_step + 4'd1;
                    r_chk <= 1'b1;
                    case (r_step)
                        4'd0: begin r_state <= S_INIT; r_cnt <= '0; r_chk <= 1'b0; end
                        4'd1: begin r_state <= S_GET_RD; r_ia <= AW'(5); r_exp <= 32'd5; end
                        4'd2: begin r_state <= S_SET; r_ia <= AW'(5); r_arg <= 32'd100; r_chk <= 1'b0; end
                        4'd3: begin r_state <= S_GET_RD; r_ia <= AW'(5); r_exp <= 32'd100; end
                        4'd4: begin r_state <= S_COPY_RD; r_ia <= AW'(5); r_ib <= AW'(6); r_chk <= 1'b0; end
                        4'd5: begin r_state <= S_GET_RD; r_ia <= AW'(6); r_exp <= 32'd100; end
                        4'd6: begin r_state <= S_INC; r_arg <= 32'd7; r_exp <= 32'd8; end
                        4'd7: begin r_state <= S_DEC; r_arg <= 32'd7; r_exp <= 32'd6; end
                        4'd8: begin r_x <= 32'd3; r_y <= 32'd4; r_chk <= 1'b0; end
                        4'd9: begin r_state <= S_SUM; r_exp <= 32'd7; end
                        4'd10, 4'd11, 4'd12, 4'd13: begin
                            r_state <= S_SWITCH;
                            r_arg <= WORD_W'(r_step - 4'd10);
                            r_exp <= switch_val(WORD_W'(r_step - 4'd10));
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_busy <= '0;
                            r_in_test <= 1'b0;
                            r_test_ret <= w_pass;
                        end
                    endcase
                end
                S_INIT: r_cnt <= r_cnt + 1'b1;
                S_COPY_RD: r_state <= S_COPY_WR;
                S_GET_RD: r_state <= S_GET_WAIT;
                default: ;
            endcase
            // Calls made by test report back to the sequencer, not to the method ports.
            if (w_done && r_in_test) begin
                r_state <= S_TEST;
                r_res <= w_res;
            end else if (w_done) begin
                r_state <= S_IDLE;
                r_busy <= '0;
                if (r_state == S_DEC) r_dec_ret <= w_res;
                if (r_state == S_INC) r_inc_ret <= w_res;
                if (r_state == S_GET_WAIT) r_get_ret <= w_res;
                if (r_state == S_SWITCH) r_sw_ret <= w_res;
                if (r_state == S_SUM) r_sum_ret <= w_res;
            end
            // External field writes override the sequencer's writes.
            if (x_we) r_x <= x_in;
            if (y_we) r_y <= y_in;
        end
    end

`ifdef ARRAY_EXT_PORT_EN
    assign w_b_we = a_we;
    assign w_b_oe = a_oe;
    assign w_b_addr = a_address[AW-1:0];
    assign w_b_din = a_din;
    assign a_dout = w_b_q;
    assign w_unused = ^{a_address[31:AW], copy_i[31:AW], copy_j[31:AW], set_i[31:AW], get_i[31:AW]};
`else
    assign w_b_we = 1'b0;
    assign w_b_oe = 1'b0;
    assign w_b_addr = '0;
    assign w_b_din = '0;
    assign a_dout = '0;
    assign w_unused = ^{a_we, a_oe, a_din, a_address, w_b_q, copy_i[31:AW], copy_j[31:AW],
                        set_i[31:AW], get_i[31:AW]};
`endif

    test002_dpram #(.ARRAY_LEN(ARRAY_LEN)) u_ram (
        .i_clk(clk), .i_rst_n(reset),
        .i_a_we(w_we), .i_a_addr(w_addr), .i_a_din(w_din), .o_a_dout(w_ram_q),
        .i_b_we(w_b_we), .i_b_oe(w_b_oe), .i_b_addr(w_b_addr), .i_b_din(w_b_din), .o_b_dout(w_b_q)
    );

    assign a_length = 32'(ARRAY_LEN);
    assign x_out = r_x;
    assign y_out = r_y;
    assign {test_busy, sum_x_y_busy, switch_test_busy, get_busy, set_busy,
            copy_busy, inc_busy, dec_busy, init_busy} = r_busy;
    assign dec_return = r_dec_ret;
    assign inc_return = r_inc_ret;
    assign get_return = r_get_ret;
    assign switch_test_return = r_sw_ret;
    assign sum_x_y_return = r_sum_ret;
    assign test_return = r_test_ret;
endmodule

// File: tb/tb_test002_methods.sv
// tb_test002_methods: directed self-checking bench for test002_methods.
module tb_test002_methods;
    logic        clk = 0, rst_n = 0;
    logic [31:0] a_address = 0, a_din = 0, x_in = 0, y_in = 0;
    logic        a_we = 0, a_oe = 0, x_we = 0, y_we = 0;
    logic [31:0] dec_i = 0, inc_i = 0, get_i = 0, switch_test_x = 0;
    logic [31:0] copy_i = 0, copy_j = 0, set_i = 0, set_v = 0;
    logic [8:0]  req = 0;
    logic [8:0]  busy;
    logic [31:0] a_dout, a_length, x_out, y_out;
    logic [31:0] dec_return, inc_return, get_return, switch_test_return, sum_x_y_return;
    logic        test_return;
    int          total = 0, bad = 0;

    localparam int INIT = 0, DEC = 1, INC = 2, COPY = 3, SET = 4, GET = 5, SW = 6, SUM = 7, TEST = 8;

    always #5 clk = ~clk;

    test002_methods dut (
        .clk(clk), .reset(rst_n),
        .a_address(a_address), .a_we(a_we), .a_oe(a_oe), .a_din(a_din), .a_dout(a_dout),
        .a_length(a_length),
        .x_in(x_in), .x_we(x_we), .x_out(x_out), .y_in(y_in), .y_we(y_we), .y_out(y_out),
        .dec_i(dec_i), .inc_i(inc_i), .get_i(get_i), .switch_test_x(switch_test_x),
        .copy_i(copy_i), .copy_j(copy_j), .set_i(set_i), .set_v(set_v),
        .init_req(req[INIT]), .dec_req(req[DEC]), .inc_req(req[INC]), .copy_req(req[COPY]),
        .set_req(req[SET]), .get_req(req[GET]), .switch_test_req(req[SW]),
        .sum_x_y_req(req[SUM]), .test_req(req[TEST]),
        .init_busy(busy[INIT]), .dec_busy(busy[DEC]), .inc_busy(busy[INC]),
        .copy_busy(busy[COPY]), .set_busy(busy[SET]), .get_busy(busy[GET]),
        .switch_test_busy(busy[SW]), .sum_x_y_busy(busy[SUM]), .test_busy(busy[TEST]),
        .dec_return(dec_return), .inc_return(inc_return), .get_return(get_return),
        .switch_test_return(switch_test_return), .sum_x_y_return(sum_x_y_return),
        .test_return(test_return)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Pulse one request, check busy rises next cycle, wait (bounded) for completion.
    task automatic call(input int m, input int limit);
        int n;
        @(negedge clk);
        req[m] = 1;
        @(posedge clk);
        #1 req[m] = 0;
        chk("busy_rise", 32'(busy[m]), 1);
        n = 0;
        while (busy[m] && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("busy_fall_in_time", 32'(busy[m]), 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_test_ret", 32'(test_return), 0);
        chk("rst_dec_ret", dec_return, 0);
        chk("rst_x", x_out, 0);
        chk("rst_a_dout", a_dout, 0);
        chk("a_length", a_length, 128);

        // test_req held from reset release
        rst_n = 1;
        req[TEST] = 1;
        @(posedge clk);
        #1 chk("test_busy_rise", 32'(busy[TEST]), 1);
        n = 0;
        while (busy[TEST] && n < 192) begin
            @(negedge clk);
            n++;
        end
        req[TEST] = 0;
        chk("test_in_time", 32'(busy[TEST]), 0);
        chk("test_ret", 32'(test_return), 1);
        chk("test_x", x_out, 3);
        chk("test_y", y_out, 4);

        call(INIT, 140);
        get_i = 9;
        call(GET, 4);
        chk("get9_init", get_return, 9);
        set_i = 9;
        set_v = 32'hDEAD;
        call(SET, 4);
        call(GET, 4);
        chk("get9_set", get_return, 32'hDEAD);
        copy_i = 9;
        copy_j = 32'd138; // index wraps to 10
        call(COPY, 4);
        get_i = 10;
        call(GET, 4);
        chk("copy_9_10", get_return, 32'hDEAD);

        inc_i = 32'hFFFF_FFFF;
        call(INC, 4);
        chk("inc_wrap", inc_return, 0);
        dec_i = 0;
        call(DEC, 4);
        chk("dec_wrap", dec_return, 32'hFFFF_FFFF);
        dec_i = 100;
        call(DEC, 4);
        chk("dec_100", dec_return, 99);
        switch_test_x = 1;
        call(SW, 4);
        chk("switch_1", switch_test_return, 20);
        switch_test_x = 7;
        call(SW, 4);
        chk("switch_7", switch_test_return, 32'hFFFF_FFFF);
        chk("dec_hold", dec_return, 99);

        @(negedge clk);
        x_in = 5;
        x_we = 1;
        y_in = 6;
        y_we = 1;
        @(negedge clk);
        x_we = 0;
        y_we = 0;
        chk("x_out", x_out, 5);
        chk("y_out", y_out, 6);
        call(SUM, 4);
        chk("sum", sum_x_y_return, 11);

        // simultaneous requests: dec outranks inc
        dec_i = 50;
        inc_i = 50;
        @(negedge clk);
        req[DEC] = 1;
        req[INC] = 1;
        @(posedge clk);
        #1 req[DEC] = 0;
        req[INC] = 0;
        chk("arb_dec_busy", 32'(busy[DEC]), 1);
        chk("arb_inc_idle", 32'(busy[INC]), 0);
        repeat (3) @(negedge clk);
        chk("arb_dec_ret", dec_return, 49);
        chk("arb_inc_ret", inc_return, 0);

        @(negedge clk);
        a_address = 9;
        a_oe = 1;
        @(negedge clk);
        a_oe = 0;
`ifdef ARRAY_EXT_PORT_EN
        chk("ext_read", a_dout, 32'hDEAD);
`else
        chk("ext_read_off", a_dout, 0);
`endif

        // reset in the middle of test
        @(negedge clk);
        req[TEST] = 1;
        @(posedge clk);
        #1 req[TEST] = 0;
        repeat (20) @(negedge clk);
        rst_n = 0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_test_ret", 32'(test_return), 0);
        chk("mid_rst_sum_ret", sum_x_y_return, 0);
        @(negedge clk);
        rst_n = 1;
        call(TEST, 192);
        chk("retest_ret", 32'(test_return), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
